// File: rtl/flag_unit_pkg.sv
// Shared definitions for the condition-flag producer: opcodes, flag bit
// positions and the per-opcode flag-write mask.
package flag_unit_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Write mask {mZ,mV,mN}: arithmetic writes all flags, logic/shift writes Z only.
  function automatic logic [2:0] flag_mask(input logic [3:0] opcode);
    logic [2:0] m;
    case (opcode)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

  // Per-bit overlay of an update onto a base flag vector.
  function automatic logic [2:0] flag_merge(input logic [2:0] base,
                                            input logic [2:0] mask,
                                            input logic [2:0] value);
    return (base & ~mask) | (value & mask);
  endfunction

endpackage

// File: rtl/flag_compute.sv
// Combinational flag generation for the EX instruction: write mask plus
// the candidate {Z,V,N} values derived from the ALU result.
module flag_compute
  import flag_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] result,
  input  logic              ovfl,
  output logic [2:0]        mask,
  output logic [2:0]        value
);

  // Mask lookup and raw flag values; V is only written by ADD/SUB via the mask.
  always_comb begin
    mask          = flag_mask(opcode);
    value         = 3'b000;
    value[FLAG_Z] = (result == {DATA_W{1'b0}});
    value[FLAG_V] = ovfl;
    value[FLAG_N] = result[DATA_W-1];
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag producer: stages EX flag updates for one cycle, commits them
// architecturally, forwards pending updates to ID and flags branch hazards.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic              flush_ex,
  input  logic              stall,
  input  logic              id_is_branch,
  output logic [2:0]        flags,
  output logic              flag_hazard
);

  logic [2:0] arch_flags_r;
  logic       pend_valid_r;
  logic [2:0] pend_mask_r;
  logic [2:0] pend_flags_r;

  logic [2:0] ex_mask_s;
  logic [2:0] ex_flags_s;
  logic [2:0] merged_s;
  logic       capture_s;

  flag_compute #(.DATA_W(DATA_W)) u_compute (
    .opcode (ex_opcode),
    .result (ex_result),
    .ovfl   (ex_ovfl),
    .mask   (ex_mask_s),
    .value  (ex_flags_s)
  );

  // The forwarded view equals the value committed at the next unstalled edge,
  // so one merge serves both the flags output and the commit path.
  always_comb begin
    capture_s = ex_valid & ~flush_ex & (ex_mask_s != 3'b000);
    if (pend_valid_r) begin
      merged_s = flag_merge(arch_flags_r, pend_mask_r, pend_flags_r);
    end else begin
      merged_s = arch_flags_r;
    end
    flags       = merged_s;
    flag_hazard = id_is_branch & capture_s;
  end

  // Architectural flags and one-deep staging register; stall freezes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      arch_flags_r <= 3'b000;
      pend_valid_r <= 1'b0;
      pend_mask_r  <= 3'b000;
      pend_flags_r <= 3'b000;
    end else if (!stall) begin
      arch_flags_r <= merged_s;
      pend_valid_r <= capture_s;
      pend_mask_r  <= ex_mask_s;
      pend_flags_r <= ex_flags_s;
    end else begin
      arch_flags_r <= arch_flags_r;
      pend_valid_r <= pend_valid_r;
      pend_mask_r  <= pend_mask_r;
      pend_flags_r <= pend_flags_r;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus randomized
// traffic scored against an update-list model of the flag register.
module tb_flag_unit;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ex_valid = 1'b0;
  logic [3:0]        ex_opcode = 4'b0000;
  logic [DATA_W-1:0] ex_result = 16'h0000;
  logic              ex_ovfl = 1'b0;
  logic              flush_ex = 1'b0;
  logic              stall = 1'b0;
  logic              id_is_branch = 1'b0;
  logic [2:0]        flags;
  logic              flag_hazard;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0] mask;
    logic [2:0] val;
  } upd_t;

  logic [2:0] m_arch = 3'b000;
  upd_t       m_pend[$];

  flag_unit #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_result    (ex_result),
    .ex_ovfl      (ex_ovfl),
    .flush_ex     (flush_ex),
    .stall        (stall),
    .id_is_branch (id_is_branch),
    .flags        (flags),
    .flag_hazard  (flag_hazard)
  );

  always #5 clk = ~clk;

  // Which flags an opcode writes: arithmetic all three, logic/shift Z only.
  function automatic logic [2:0] ref_mask(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 3'b111;
    if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic ref_sets(input logic v, input logic f, input logic [3:0] op);
    return v && !f && (ref_mask(op) != 3'b000);
  endfunction

  // Newest visible flags: architectural value with every pending update applied in order.
  function automatic logic [2:0] ref_flags();
    logic [2:0] r;
    r = m_arch;
    foreach (m_pend[k])
      for (int b = 0; b < 3; b++)
        if (m_pend[k].mask[b]) r[b] = m_pend[k].val[b];
    return r;
  endfunction

  function automatic logic ref_hazard();
    return id_is_branch && ref_sets(ex_valid, flush_ex, ex_opcode);
  endfunction

  // One rising edge, then advance the model with the inputs that were presented.
  task automatic step();
    upd_t u;
    @(posedge clk);
    if (rst) begin
      m_arch = 3'b000;
      m_pend.delete();
    end else if (!stall) begin
      m_arch = ref_flags();
      m_pend.delete();
      if (ref_sets(ex_valid, flush_ex, ex_opcode)) begin
        u.mask = ref_mask(ex_opcode);
        u.val  = {(ex_result == 16'h0000), ex_ovfl, ex_result[DATA_W-1]};
        m_pend.push_back(u);
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic fl);
    ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ov; flush_ex = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (flags !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags[%0d]: got %b want 000", i, flags);
      end
    end
    rst = 1'b0;
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (flags !== 3'b000) begin
      n_fail++; $display("FAIL reset_release: got %b want 000", flags);
    end
  endtask

  task automatic test_add_latency();
    drive(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (flags !== 3'b110) begin
      n_fail++; $display("FAIL add_fwd: got %b want 110", flags);
    end
    drive(1'b0, 4'b0000, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (flags !== 3'b110) begin
        n_fail++; $display("FAIL add_hold[%0d]: got %b want 110", i, flags);
      end
    end
  endtask

  task automatic test_merge();
    drive(1'b1, 4'b0001, 16'h8000, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (flags !== 3'b001) begin
      n_fail++; $display("FAIL sub_flags: got %b want 001", flags);
    end
    drive(1'b1, 4'b0010, 16'h0000, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (flags !== 3'b101) begin
      n_fail++; $display("FAIL xor_merge: got %b want 101", flags);
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (flags !== 3'b101) begin
      n_fail++; $display("FAIL merge_commit: got %b want 101", flags);
    end
  endtask

  task automatic test_nonsetting();
    drive(1'b1, 4'b0001, 16'h8000, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'b1000, 16'h0000, 1'b1, 1'b0);   // LW
    step();
    n_cmp++;
    if (flags !== 3'b001) begin
      n_fail++; $display("FAIL lw_keep: got %b want 001", flags);
    end
    drive(1'b1, 4'b0111, 16'h0000, 1'b1, 1'b0);   // PADDSB
    step();
    n_cmp++;
    if (flags !== 3'b001) begin
      n_fail++; $display("FAIL paddsb_keep: got %b want 001", flags);
    end
    drive(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b1);   // flushed ADD
    step();
    n_cmp++;
    if (flags !== 3'b001) begin
      n_fail++; $display("FAIL flush_keep: got %b want 001", flags);
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_hazard();
    logic [3:0] ops[4]   = '{4'b0100, 4'b0100, 4'b1010, 4'b0100};
    logic       fls[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       brs[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       want[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 16'h0001, 1'b0, fls[i]);
      id_is_branch = brs[i];
      stall = (i == 0);
      #1;
      n_cmp++;
      if (flag_hazard !== want[i]) begin
        n_fail++; $display("FAIL hazard[%0d]: got %b want %b", i, flag_hazard, want[i]);
      end
    end
    stall = 1'b0;
    id_is_branch = 1'b0;
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_stall();
    drive(1'b1, 4'b0000, 16'h0005, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (flags !== 3'b000) begin
      n_fail++; $display("FAIL stall_add: got %b want 000", flags);
    end
    drive(1'b1, 4'b0010, 16'h0000, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (flags !== 3'b000) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %b want 000", i, flags);
      end
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (flags !== 3'b100) begin
      n_fail++; $display("FAIL stall_release: got %b want 100", flags);
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [2:0] exp_f;
    logic       exp_h;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      id_is_branch = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       ex_result = 16'h0000;
        1:       ex_result = 16'h8000 | 16'($urandom_range(0, 255));
        default: ex_result = 16'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ex_result,
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      #1;
      exp_h = ref_hazard();
      n_cmp++;
      if (flag_hazard !== exp_h) begin
        n_fail++; $display("FAIL rand_hazard[%0d]: got %b want %b", i, flag_hazard, exp_h);
      end
      step();
      exp_f = ref_flags();
      n_cmp++;
      if (flags !== exp_f) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got %b want %b", i, flags, exp_f);
      end
    end
    rst = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_add_latency();
    test_merge();
    test_nonsetting();
    test_hazard();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
